// File: rtl/game_defs.sv
// Shared definitions for the code-entry game: digit range, digit width and
// the controller state encoding seen on state_o.
package game_defs;

   localparam int DIGIT_W   = 4;
   localparam int DIGIT_MAX = 9;

   typedef enum logic [2:0] {
      ST_SET_CODE = 3'd0,
      ST_GUESS    = 3'd1,
      ST_CHECK    = 3'd2,
      ST_UNLOCKED = 3'd3,
      ST_LOCKED   = 3'd4
   } state_t;

endpackage

// File: rtl/rise_pulse.sv
// Rising-edge detector for an already-synchronised button level.
// pulse_out is high for the single cycle in which level_in is high and was
// low on the previous clock edge, so a held button yields one pulse.
module rise_pulse (
   input  logic clk,
   input  logic rst,
   input  logic level_in,
   output logic pulse_out
);

   logic level_q;
   logic level_d;

   // Next value of the delayed level is simply the current level.
   always_comb begin
      level_d = level_in;
   end

   // Delay register; cleared by reset so a level already high after reset
   // counts as a fresh edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level_d;
      end
   end

   assign pulse_out = level_in & ~level_q;

endmodule

// File: rtl/code_entry_checker.sv
// Code-entry game controller: the first group of digits becomes the secret,
// later groups are guesses checked against it, with a limited number of
// wrong guesses before a terminal lockout.
module code_entry_checker
   import game_defs::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int MAX_ATTEMPTS = 3,
   parameter int DIGIT_W      = game_defs::DIGIT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DIGIT_W-1:0] digit_in,
   input  logic               enter,
   input  logic               clear,
   input  logic               relock,
   output logic [2:0]         entry_count,
   output logic [1:0]         attempts_left,
   output logic               code_set,
   output logic               unlocked,
   output logic               locked_out,
   output logic               bad_guess,
   output logic               entry_err,
   output logic [2:0]         state_o
);

   localparam int         CODE_W    = NUM_DIGITS * DIGIT_W;
   localparam logic [2:0] CNT_LAST  = 3'(NUM_DIGITS - 1);
   localparam logic [1:0] ATT_FULL  = 2'(MAX_ATTEMPTS);

   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [1:0]          att_q, att_d;
   logic                code_set_q, code_set_d;
   logic                bad_guess_q, bad_guess_d;
   logic                entry_err_q, entry_err_d;
   logic [CODE_W-1:0]   secret_q, secret_d;
   logic [CODE_W-1:0]   guess_q, guess_d;
   logic                cap;
   logic                digit_ok;
   logic                last_slot;

   // Only the rising edge of enter captures a digit.
   rise_pulse u_enter_edge (
      .clk       (clk),
      .rst       (rst),
      .level_in  (enter),
      .pulse_out (cap)
   );

   assign digit_ok  = (digit_in <= DIGIT_W'(DIGIT_MAX));
   assign last_slot = (cnt_q == CNT_LAST);

   // Next-state logic: digit capture, group completion, guess check and relock.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      att_d       = att_q;
      code_set_d  = code_set_q;
      bad_guess_d = 1'b0;
      entry_err_d = 1'b0;
      secret_d    = secret_q;
      guess_d     = guess_q;

      case (state_q)
         ST_SET_CODE, ST_GUESS: begin
            // clear has priority over a simultaneous capture
            if (clear) begin
               cnt_d = 3'd0;
            end else if (cap) begin
               if (!digit_ok) begin
                  entry_err_d = 1'b1;
               end else begin
                  // Both secret and guess are assembled in the guess store;
                  // a finished secret group is then copied across.
                  for (int i = 0; i < NUM_DIGITS; i++) begin
                     if (cnt_q == 3'(i)) begin
                        guess_d[i*DIGIT_W +: DIGIT_W] = digit_in;
                     end
                  end
                  if (last_slot) begin
                     cnt_d = 3'd0;
                     if (state_q == ST_SET_CODE) begin
                        secret_d   = guess_d;
                        code_set_d = 1'b1;
                        state_d    = ST_GUESS;
                     end else begin
                        state_d    = ST_CHECK;
                     end
                  end else begin
                     cnt_d = cnt_q + 3'd1;
                  end
               end
            end
         end

         ST_CHECK: begin
            if (guess_q == secret_q) begin
               state_d = ST_UNLOCKED;
            end else begin
               bad_guess_d = 1'b1;
               if (att_q != 2'd0) begin
                  att_d = att_q - 2'd1;
               end
               state_d = (att_q <= 2'd1) ? ST_LOCKED : ST_GUESS;
            end
         end

         ST_UNLOCKED: begin
            if (relock) begin
               state_d = ST_GUESS;
               att_d   = ATT_FULL;
               cnt_d   = 3'd0;
            end
         end

         ST_LOCKED: begin
            // terminal until reset
         end

         default: begin
            state_d = ST_SET_CODE;
         end
      endcase
   end

   // State and datapath registers; reset also forgets the secret.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_SET_CODE;
         cnt_q       <= 3'd0;
         att_q       <= ATT_FULL;
         code_set_q  <= 1'b0;
         bad_guess_q <= 1'b0;
         entry_err_q <= 1'b0;
         secret_q    <= '0;
         guess_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         att_q       <= att_d;
         code_set_q  <= code_set_d;
         bad_guess_q <= bad_guess_d;
         entry_err_q <= entry_err_d;
         secret_q    <= secret_d;
         guess_q     <= guess_d;
      end
   end

   assign entry_count   = cnt_q;
   assign attempts_left = att_q;
   assign code_set      = code_set_q;
   assign unlocked      = (state_q == ST_UNLOCKED);
   assign locked_out    = (state_q == ST_LOCKED);
   assign bad_guess     = bad_guess_q;
   assign entry_err     = entry_err_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_code_entry_checker.sv
// Self-checking bench for code_entry_checker: directed scenarios followed by
// random stimulus, all compared against a digit-list reference model.
module tb_code_entry_checker;

   localparam int N   = 4;
   localparam int MAX = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] digit_in = 4'd0;
   logic       enter = 1'b0;
   logic       clear = 1'b0;
   logic       relock = 1'b0;
   logic [2:0] entry_count;
   logic [1:0] attempts_left;
   logic       code_set, unlocked, locked_out, bad_guess, entry_err;
   logic [2:0] state_o;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: modes as plain numbers, digit groups as queues.
   int m_mode;
   int m_group[$];
   int m_secret[$];
   int m_guess[$];
   int m_att;
   bit m_code_set, m_bad, m_err, m_prev_en;

   code_entry_checker #(.NUM_DIGITS(N), .MAX_ATTEMPTS(MAX), .DIGIT_W(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .digit_in      (digit_in),
      .enter         (enter),
      .clear         (clear),
      .relock        (relock),
      .entry_count   (entry_count),
      .attempts_left (attempts_left),
      .code_set      (code_set),
      .unlocked      (unlocked),
      .locked_out    (locked_out),
      .bad_guess     (bad_guess),
      .entry_err     (entry_err),
      .state_o       (state_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs sampled there.
   task automatic model_edge(input bit r, input bit e, input int d, input bit c, input bit rl);
      bit cap;
      int same;
      cap = e && !m_prev_en;
      m_prev_en = e;
      m_bad = 0;
      m_err = 0;
      if (r) begin
         m_mode = 0; m_att = MAX; m_code_set = 0; m_prev_en = 0;
         m_group.delete(); m_secret.delete(); m_guess.delete();
         return;
      end
      case (m_mode)
         0, 1: begin
            if (c) m_group.delete();
            else if (cap) begin
               $display("[TB] t=%0t capture digit=%0d mode=%0d", $time, d, m_mode);
               if (d > 9) m_err = 1;
               else begin
                  m_group.push_back(d);
                  if (m_group.size() == N) begin
                     if (m_mode == 0) begin
                        m_secret = m_group; m_code_set = 1; m_mode = 1;
                     end else begin
                        m_guess = m_group; m_mode = 2;
                     end
                     m_group.delete();
                  end
               end
            end
         end
         2: begin
            same = 0;
            for (int i = 0; i < N; i++) if (m_guess[i] == m_secret[i]) same++;
            if (same == N) m_mode = 3;
            else begin
               m_att = m_att - 1;
               m_bad = 1;
               m_mode = (m_att == 0) ? 4 : 1;
            end
         end
         3: if (rl) begin
            m_mode = 1; m_att = MAX; m_group.delete();
         end
         default: ;
      endcase
   endtask

   task automatic compare_all();
      check_eq("state_o", state_o, m_mode);
      check_eq("entry_count", entry_count, m_group.size());
      check_eq("attempts_left", attempts_left, m_att);
      check_eq("code_set", code_set, m_code_set);
      check_eq("unlocked", unlocked, m_mode == 3);
      check_eq("locked_out", locked_out, m_mode == 4);
      check_eq("bad_guess", bad_guess, m_bad);
      check_eq("entry_err", entry_err, m_err);
   endtask

   task automatic step(input bit r, input bit e, input int d, input bit c, input bit rl);
      @(negedge clk);
      rst = r; enter = e; digit_in = 4'(d); clear = c; relock = rl;
      @(posedge clk);
      model_edge(r, e, d, c, rl);
      #1;
      compare_all();
   endtask

   task automatic press(input int d);
      step(0, 1, d, 0, 0);
      step(0, 0, d, 0, 0);
   endtask

   task automatic do_reset();
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
   endtask

   task automatic enter_group(input int a, input int b, input int c, input int d);
      press(a); press(b); press(c); press(d);
   endtask

   initial begin
      // 1: reset state, then secret 1234
      step(1, 0, 0, 0, 0);
      check_eq("t1_reset_state", state_o, 0);
      check_eq("t1_reset_att", attempts_left, 3);
      step(0, 0, 0, 0, 0);
      enter_group(1, 2, 3, 4);
      check_eq("t1_code_set", code_set, 1);
      check_eq("t1_state_guess", state_o, 1);
      check_eq("t1_count0", entry_count, 0);

      // 2: held enter captures once; clear beats a simultaneous capture
      for (int i = 0; i < 10; i++) step(0, 1, 5, 0, 0);
      check_eq("t2_held_one_cap", entry_count, 1);
      step(0, 0, 5, 0, 0);
      step(0, 1, 7, 1, 0);
      check_eq("t2_clear_wins", entry_count, 0);
      step(0, 0, 7, 0, 0);

      // 3: correct guess, then relock
      press(1); press(2); press(3);
      step(0, 1, 4, 0, 0);
      check_eq("t3_check_state", state_o, 2);
      step(0, 0, 4, 0, 0);
      check_eq("t3_unlocked", unlocked, 1);
      check_eq("t3_att_kept", attempts_left, 3);
      press(8);
      check_eq("t3_cap_ignored", entry_count, 0);
      step(0, 0, 0, 0, 1);
      check_eq("t3_relock_state", state_o, 1);
      check_eq("t3_relock_unl", unlocked, 0);
      step(0, 0, 0, 0, 0);

      // 4: three wrong guesses lead to lockout
      enter_group(1, 2, 4, 3);
      check_eq("t4_att2", attempts_left, 2);
      enter_group(0, 0, 0, 0);
      check_eq("t4_att1", attempts_left, 1);
      press(9); press(9); press(9);
      step(0, 1, 9, 0, 0);
      step(0, 0, 9, 0, 0);
      check_eq("t4_bad_pulse", bad_guess, 1);
      check_eq("t4_att0", attempts_left, 0);
      check_eq("t4_locked", locked_out, 1);
      press(1);
      step(0, 0, 0, 1, 1);
      check_eq("t4_stays_locked", state_o, 4);

      // 5: out-of-range digit rejected, 9 accepted
      do_reset();
      enter_group(1, 2, 3, 4);
      step(0, 1, 12, 0, 0);
      check_eq("t5_entry_err", entry_err, 1);
      check_eq("t5_count_held", entry_count, 0);
      step(0, 0, 12, 0, 0);
      check_eq("t5_err_one_cycle", entry_err, 0);
      press(9);
      check_eq("t5_nine_ok", entry_count, 1);

      // 6: reset from CHECK and from UNLOCKED
      press(9); press(9);
      step(0, 1, 9, 0, 0);
      step(1, 0, 0, 0, 0);
      check_eq("t6_rst_check", state_o, 0);
      check_eq("t6_rst_codeset", code_set, 0);
      step(0, 0, 0, 0, 0);
      enter_group(5, 6, 7, 8);
      enter_group(5, 6, 7, 8);
      step(0, 0, 0, 0, 0);
      check_eq("t6_unlocked", unlocked, 1);
      step(1, 0, 0, 0, 0);
      check_eq("t6_rst_unl_state", state_o, 0);
      check_eq("t6_rst_unl_flag", unlocked, 0);
      check_eq("t6_rst_att", attempts_left, 3);

      // Random phase: small digit alphabet so matches and lockouts both occur
      for (int i = 0; i < 3000; i++) begin
         bit r, e, c, rl;
         int d;
         r  = ($urandom_range(0, 199) == 0);
         e  = $urandom_range(0, 1) == 1;
         c  = ($urandom_range(0, 29) == 0);
         rl = ($urandom_range(0, 9) == 0);
         d  = ($urandom_range(0, 19) == 0) ? $urandom_range(10, 15) : $urandom_range(1, 2);
         step(r, e, d, c, rl);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
